// File: rtl/fall_monitor_if.sv
// Per-frame signals between the game-state controller and fall_monitor.
interface fall_monitor_if;
   logic       frame_clk;
   logic       restart;
   logic [9:0] doodle_y;
   logic       monster_hit;
   logic       drop;
   logic       death;

   modport master (output frame_clk, restart, doodle_y, monster_hit, input drop, death);
   modport slave  (input frame_clk, restart, doodle_y, monster_hit, output drop, death);
endinterface

// File: rtl/fall_monitor.sv
// Per-frame drop/death detector for the doodle; sticky outputs cleared by restart.
// Optional monster-contact detection is compiled in with FALL_MONITOR_MONSTER_EN.
//
// state   | meaning
// ARMED   | post reset/restart grace period, no detection
// ALIVE   | on screen, watching for fall start and monster contact
// FALLING | below screen, counting consecutive below-screen frames
// DROPPED | sticky drop indication
// DEAD    | sticky death indication (monster build only)
module fall_monitor #(
   parameter logic [9:0] SCREEN_BOTTOM = 10'd479,
   parameter logic [3:0] FALL_FRAMES   = 4'd8,
   parameter logic [1:0] HIT_FRAMES    = 2'd2,
   parameter logic [5:0] GRACE_FRAMES  = 6'd30
) (
   input logic           Clk,
   input logic           Reset,
   fall_monitor_if.slave bus
);

   typedef enum logic [2:0] {
      ARMED   = 3'd0,
      ALIVE   = 3'd1,
      FALLING = 3'd2,
      DROPPED = 3'd3,
      DEAD    = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic       frame_q, frame_d;
   logic       tick_q, tick_d;
   logic [5:0] grace_q, grace_d;
   logic [3:0] below_q, below_d;
   logic       drop_q, drop_d;
   logic       dead_hit;
`ifdef FALL_MONITOR_MONSTER_EN
   logic [1:0] hit_q, hit_d;
   logic       death_q, death_d;
`else
   logic       unused_monster_hit;
   assign unused_monster_hit = bus.monster_hit;
`endif

   always_comb begin
      frame_d  = bus.frame_clk;
      tick_d   = bus.frame_clk & ~frame_q;
      state_d  = state_q;
      grace_d  = grace_q;
      below_d  = below_q;
      dead_hit = 1'b0;
`ifdef FALL_MONITOR_MONSTER_EN
      hit_d    = hit_q;
`endif
      if (bus.restart) begin
         state_d = ARMED;
         grace_d = 6'd0;
         below_d = 4'd0;
`ifdef FALL_MONITOR_MONSTER_EN
         hit_d   = 2'd0;
`endif
      end else if (tick_q) begin
         case (state_q)
            ARMED: begin
               if (grace_q == GRACE_FRAMES) state_d = ALIVE;
               else if (grace_q != 6'h3f)   grace_d = grace_q + 6'd1;
            end
            ALIVE, FALLING: begin
`ifdef FALL_MONITOR_MONSTER_EN
               if (bus.monster_hit) hit_d = (hit_q == 2'd3) ? 2'd3 : hit_q + 2'd1;
               else                 hit_d = 2'd0;
               dead_hit = (hit_d == HIT_FRAMES);
`endif
               // Monster contact outranks a fall completing on the same tick.
               if (dead_hit) begin
                  state_d = DEAD;
               end else if (bus.doodle_y > SCREEN_BOTTOM) begin
                  if (state_q == ALIVE)       below_d = 4'd1;
                  else if (below_q != 4'hf)   below_d = below_q + 4'd1;
                  state_d = (below_d == FALL_FRAMES) ? DROPPED : FALLING;
               end else begin
                  below_d = 4'd0;
                  state_d = ALIVE;
               end
            end
            default: ;
         endcase
      end
      drop_d = (state_d == DROPPED);
`ifdef FALL_MONITOR_MONSTER_EN
      death_d = (state_d == DEAD);
`endif
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ARMED;
         frame_q <= 1'b0;
         tick_q  <= 1'b0;
         grace_q <= 6'd0;
         below_q <= 4'd0;
         drop_q  <= 1'b0;
`ifdef FALL_MONITOR_MONSTER_EN
         hit_q   <= 2'd0;
         death_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         tick_q  <= tick_d;
         grace_q <= grace_d;
         below_q <= below_d;
         drop_q  <= drop_d;
`ifdef FALL_MONITOR_MONSTER_EN
         hit_q   <= hit_d;
         death_q <= death_d;
`endif
      end
   end

   assign bus.drop  = drop_q;
`ifdef FALL_MONITOR_MONSTER_EN
   assign bus.death = death_q;
`else
   assign bus.death = 1'b0;
`endif

endmodule

// File: tb/tb_fall_monitor.sv
// Directed bench for fall_monitor: vector table plus hand sequences for grace, timing and restart.
module tb_fall_monitor;
   logic clk;
   logic reset;
   int   total;
   int   bad;

   fall_monitor_if bus();

   fall_monitor dut (.Clk(clk), .Reset(reset), .bus(bus.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         realive;
      int         hold;
      logic [9:0] y;
      logic       hit;
      logic       exp_drop;
      logic       exp_death;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic frame(input logic [9:0] y, input logic hit, input int hold);
      @(negedge clk);
      bus.doodle_y    = y;
      bus.monster_hit = hit;
      bus.frame_clk   = 1'b1;
      repeat (hold) @(negedge clk);
      bus.frame_clk   = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic go_alive();
      do_reset();
      repeat (31) frame(10'd300, 1'b0, 2);
   endtask

   task automatic add(input bit ra, input int hold, input logic [9:0] y, input logic hit,
                      input logic ed, input logic eh);
      vec_t v;
      v.realive = ra; v.hold = hold; v.y = y; v.hit = hit; v.exp_drop = ed; v.exp_death = eh;
      vecs.push_back(v);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      bus.frame_clk   = 1'b0;
      bus.restart     = 1'b0;
      bus.doodle_y    = 10'd500;
      bus.monster_hit = 1'b0;

      // Monster pattern 1,0,1,1 then a below-screen frame.
`ifdef FALL_MONITOR_MONSTER_EN
      add(1, 2, 10'd300, 1'b1, 1'b0, 1'b0);
      add(0, 2, 10'd300, 1'b0, 1'b0, 1'b0);
      add(0, 2, 10'd300, 1'b1, 1'b0, 1'b0);
      add(0, 2, 10'd300, 1'b1, 1'b0, 1'b1);
      add(0, 2, 10'd600, 1'b0, 1'b0, 1'b1);
`else
      add(1, 2, 10'd300, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) add(0, 2, 10'd300, 1'b1, 1'b0, 1'b0);
`endif
      // Simultaneous hit completion and fall completion.
      add(1, 2, 10'd480, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) add(0, 2, 10'd480, 1'b0, 1'b0, 1'b0);
      add(0, 2, 10'd480, 1'b1, 1'b0, 1'b0);
`ifdef FALL_MONITOR_MONSTER_EN
      add(0, 2, 10'd480, 1'b1, 1'b0, 1'b1);
`else
      add(0, 2, 10'd480, 1'b1, 1'b1, 1'b0);
`endif
      // Long frame pulse counts once.
      add(1, 100, 10'd480, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) add(0, 2, 10'd480, 1'b0, 1'b0, 1'b0);
      add(0, 2, 10'd480, 1'b0, 1'b1, 1'b0);

      // Reset and grace with the doodle below the screen throughout.
      bus.doodle_y = 10'd500;
      do_reset();
      chk("reset_drop", bus.drop, 1'b0);
      chk("reset_death", bus.death, 1'b0);
      for (int i = 1; i <= 39; i++) begin
         frame(10'd500, 1'b0, 2);
         chk($sformatf("grace_drop_f%0d", i), bus.drop, (i == 39));
      end

      // Fall recovery and exact output latency.
      go_alive();
      for (int i = 0; i < 15; i++) begin
         frame((i == 7) ? 10'd300 : 10'd480, 1'b0, 2);
         chk($sformatf("recov_drop_f%0d", i), bus.drop, 1'b0);
      end
      @(negedge clk);
      bus.doodle_y  = 10'd480;
      bus.frame_clk = 1'b1;
      @(negedge clk);
      chk("lat_drop_e0", bus.drop, 1'b0);
      @(negedge clk);
      chk("lat_drop_e1", bus.drop, 1'b1);
      bus.frame_clk = 1'b0;
      repeat (2) @(negedge clk);

      // Restart clears the sticky output on the next edge.
      bus.restart = 1'b1;
      @(negedge clk);
      bus.restart = 1'b0;
      chk("restart_clears_drop", bus.drop, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].realive) go_alive();
         frame(vecs[i].y, vecs[i].hit, vecs[i].hold);
         chk($sformatf("vec%0d_drop", i), bus.drop, vecs[i].exp_drop);
         chk($sformatf("vec%0d_death", i), bus.death, vecs[i].exp_death);
      end

      // Restart in FALLING with five below-screen frames counted.
      go_alive();
      repeat (5) frame(10'd600, 1'b0, 2);
      @(negedge clk);
      bus.restart = 1'b1;
      @(negedge clk);
      bus.restart = 1'b0;
      chk("mid_restart_drop", bus.drop, 1'b0);
      chk("mid_restart_death", bus.death, 1'b0);
      for (int i = 1; i <= 39; i++) begin
         frame(10'd600, 1'b0, 2);
         chk($sformatf("post_restart_drop_f%0d", i), bus.drop, (i == 39));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fall_monitor.md
# fall_monitor

Per-frame game-condition detector for Doodle Jump. Watches the doodle's vertical position and monster-overlap flag once per video frame. Produces the sticky `drop` (fell off screen bottom) and `death` (monster contact) indications consumed by the game-state controller. Its counters and flags are cleared by the controller's `restart` level.

## Interface
Parameters:
- `SCREEN_BOTTOM`, default 10'd479: largest on-screen doodle Y. Y strictly greater than this is below the screen.
- `FALL_FRAMES`, default 4'd8: consecutive below-screen frames required to assert `drop`. Legal range 1–15.
- `HIT_FRAMES`, default 2'd2: consecutive monster-overlap frames required to assert `death`. Legal range 1–3.
- `GRACE_FRAMES`, default 6'd30: frames after restart/reset during which detection is suppressed. Legal range 0–63.

Ports:
- `Clk` in 1: system clock. All state is on its rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `frame_clk` in 1: vertical-sync-rate frame clock, synchronous to `Clk`.
- `restart` in 1: level from the controller. While high, the block is held in its post-reset condition.
- `doodle_y` in 10: unsigned doodle top Y, updated once per frame.
- `monster_hit` in 1: doodle/monster bounding-box overlap, valid per frame.
- `drop` out 1: sticky. Doodle has fallen below the screen.
- `death` out 1: sticky. Doodle killed by a monster.

## Operation
- Frame tick generation:
  - `frame_d <= frame_clk`
  - `tick <= frame_clk & ~frame_d`, a registered one-`Clk` pulse per frame.
  - All counters and state advance only on cycles where `tick` is 1.
- Counters:
  - `grace_cnt` is 6 bits, `below_cnt` is 4 bits, `hit_cnt` is 2 bits.
  - All counters saturate and never wrap.
- States:
  - **ARMED**: entered on reset/restart. Each tick increments `grace_cnt`. When `grace_cnt == GRACE_FRAMES` at a tick, go to ALIVE. With `GRACE_FRAMES == 0`, the first tick goes to ALIVE. No detection happens in ARMED.
  - **ALIVE**: on each tick, evaluate in priority order:
    - If `monster_hit` is 1, increment `hit_cnt`; otherwise clear it.
    - If the new `hit_cnt == HIT_FRAMES`, go to DEAD.
    - Else if `doodle_y > SCREEN_BOTTOM`, set `below_cnt = 1`. If `FALL_FRAMES == 1`, go to DROPPED; otherwise go to FALLING.
  - **FALLING**: on each tick:
    - Monster-hit evaluation is identical to ALIVE and takes priority.
    - If `doodle_y > SCREEN_BOTTOM`, increment `below_cnt`. Reaching `FALL_FRAMES` goes to DROPPED.
    - Otherwise clear `below_cnt` and return to ALIVE.
  - **DROPPED**: `drop = 1`, `death = 0`. Ignores all inputs except `restart`/`Reset`.
  - **DEAD**: `death = 1`, `drop = 0`. Ignores all inputs except `restart`/`Reset`.
- Outputs are registered and decoded from state. `drop` and `death` are never both 1.
- Priority: `Reset` > `restart` > tick processing.
  - `restart` high on any cycle forces ARMED, clears all counters, and clears both outputs on the next edge, including mid-FALLING.
  - Processing resumes on the first tick after `restart` falls.
- Simultaneous events: if a monster hit completes `HIT_FRAMES` and the fall count completes on the same tick, DEAD wins.

## Timing
- Reset values:
  - `drop = 0`, `death = 0`
  - state ARMED, all counters 0
  - `frame_d = 0`, `tick = 0`
- Let E0 be the `Clk` edge sampling `frame_clk = 1` with `frame_d = 0`. `tick` is high after E0. Inputs are sampled and state updates at E1. Outputs change after E1, i.e. 2 `Clk` cycles after `frame_clk` rises.
- `doodle_y` and `monster_hit` must be stable from E0 through E1.
- A `frame_clk` held high for many cycles produces exactly one tick.
- `restart`/`Reset` take effect at the next edge; outputs are 0 one cycle later.

## Configuration
- `FALL_MONITOR_MONSTER_EN`:
  - Defined: `hit_cnt`, the DEAD state and monster-hit evaluation are compiled in, as described above.
  - Undefined: `monster_hit` is unused, `hit_cnt` and DEAD are removed, and `death` is tied to 0. The controller then reaches its dead screen only through the drop timeout.

## Test plan
- **Reset and grace**: `Reset` 1 cycle with `doodle_y = 500` held, default parameters. `drop` must stay 0 for the first 30 ticks, then be 1 after the 9th tick beyond grace (1 tick ARMED→ALIVE transition, then 8 below-screen ticks).
- **Fall recovery**: in ALIVE, drive `doodle_y = 480` for 7 ticks, then 300 for 1 tick, then 480 for 8 ticks. `drop` stays 0 until the final 8th consecutive tick, then is 1 exactly 2 `Clk` after that `frame_clk` rise.
- **Monster death**: in ALIVE, `monster_hit` pattern 1,0,1,1. `death` rises after the 4th tick. A subsequent `doodle_y = 600` leaves `drop = 0`.
- **Simultaneous events**: at `below_cnt = 7`, `hit_cnt = 1`, a tick with `doodle_y = 480` and `monster_hit = 1` gives `death = 1` and `drop = 0`.
- **Restart mid-operation**: in FALLING with `below_cnt = 5`, pulse `restart` 1 cycle. Outputs are 0, and the next 30 ticks with `doodle_y = 600` do not assert `drop`.
- **Long frame pulse**: `frame_clk` high for 100 cycles with `doodle_y = 480` in ALIVE produces exactly one `below_cnt` increment. Additionally, with `FALL_MONITOR_MONSTER_EN` undefined, `monster_hit = 1` held for 10 ticks keeps `death = 0`.
